mii_rx: RTL

Receive-side framer between the PHY0 MII receive pins and the MAC's internal byte stream. It strips preamble and SFD, assembles nibbles into bytes, checks the Ethernet FCS, and strips it from the output. It emits an unbuffered byte stream with a per-frame good/bad verdict on the last byte. It is the receive counterpart of the MAC's nibble transmitter; the MII does not allow stalling, so there is no backpressure.

---
 rtl/mii_rx.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/mii_rx.sv
// mii_rx: MII receive framer for PHY0.
// Strips preamble/SFD, holds back the FCS, checks CRC and length.
module mii_rx #(
  parameter int MIN_FRAME = 64,
  parameter int MAX_FRAME = 1518
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] phy_rxd,
  input  logic       phy_rxctl,
  output logic [7:0] m_data,
  output logic       m_valid,
  output logic       m_last,
  output logic       m_error,
  output logic       rx_good,
  output logic       rx_bad
);

  typedef enum logic [1:0] {
    IDLE,
    PRE,
    DATA,
    DROP
  } state_t;

  localparam logic [31:0] RESIDUE = 32'hDEBB20E3;
  localparam logic [31:0] POLY    = 32'hEDB88320;
  localparam logic [10:0] LEN_MIN = 11'(MIN_FRAME);
  localparam logic [10:0] LEN_MAX = 11'(MAX_FRAME);
  localparam logic [10:0] LEN_SAT = 11'(MAX_FRAME + 1);

  state_t      state, state_d;
  logic [3:0]  lo_q;
  logic        half_q;
  logic [7:0]  sh_q [5];
  logic [10:0] len_q;
  logic [31:0] crc_q;

  logic       sfd, take, fr_bad;
  logic       emit, last_d, err_d, good_d, bad_d;
  logic [7:0] byte_in;

  function automatic logic [31:0] crc_byte(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
    return r;
  endfunction

  assign byte_in = {phy_rxd, lo_q};
  assign take    = (state == DATA) && phy_rxctl && half_q;
  assign fr_bad  = (crc_q != RESIDUE) || half_q ||
                   (len_q < LEN_MIN);

  always_comb begin
    state_d = state;
    sfd     = 1'b0;
    emit    = 1'b0;
    last_d  = 1'b0;
    err_d   = 1'b0;
    good_d  = 1'b0;
    bad_d   = 1'b0;
    unique case (state)
      IDLE: begin
        if (phy_rxctl)
          state_d = (phy_rxd == 4'h5) ? PRE : DROP;
      end
      PRE: begin
        if (!phy_rxctl) begin
          state_d = IDLE;
        end else if (phy_rxd == 4'hD) begin
          state_d = DATA;
          sfd     = 1'b1;
        end else if (phy_rxd != 4'h5) begin
          state_d = DROP;
        end
      end
      DATA: begin
        if (!phy_rxctl) begin
          state_d = IDLE;
          if (len_q < 11'd5) begin
            bad_d = 1'b1;
          end else begin
            emit   = 1'b1;
            last_d = 1'b1;
            err_d  = fr_bad;
            good_d = !fr_bad;
            bad_d  = fr_bad;
          end
        end else if (half_q) begin
          // byte N leaves once byte N+5 lands
          emit = (len_q >= 11'd5);
          if (len_q == LEN_MAX) begin
            last_d  = 1'b1;
            err_d   = 1'b1;
            bad_d   = 1'b1;
            state_d = DROP;
          end
        end
      end
      DROP: begin
        if (!phy_rxctl)
          state_d = IDLE;
      end
      default: state_d = DROP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= DROP;
      m_data  <= 8'd0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_error <= 1'b0;
      rx_good <= 1'b0;
      rx_bad  <= 1'b0;
      lo_q    <= 4'd0;
      half_q  <= 1'b0;
      len_q   <= 11'd0;
      crc_q   <= 32'hFFFFFFFF;
    end else begin
      state   <= state_d;
      m_valid <= emit;
      m_last  <= last_d;
      m_error <= err_d;
      rx_good <= good_d;
      rx_bad  <= bad_d;
      if (emit)
        m_data <= sh_q[4];
      if (sfd) begin
        half_q <= 1'b0;
        len_q  <= 11'd0;
        crc_q  <= 32'hFFFFFFFF;
      end else if (state == DATA && phy_rxctl) begin
        half_q <= !half_q;
        if (!half_q)
          lo_q <= phy_rxd;
        if (half_q) begin
          crc_q <= crc_byte(crc_q, byte_in);
          if (len_q != LEN_SAT)
            len_q <= len_q + 11'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (take) begin
      sh_q[0] <= byte_in;
      for (int i = 1; i < 5; i++)
        sh_q[i] <= sh_q[i-1];
    end
  end

endmodule
